// File: rtl/spi_pkg.sv
// Shared SPI definitions: arbiter state encoding and default command/data widths
// used by spi_ctrl clients.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  localparam int SPI_CMD_WIDTH  = 24;
  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_CMD_RW_BIT = 23;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first valid requester searching upward,
// with wrap, from last_grant+1.
module spi_rr_pick
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
      if (!o_any && i_req_valid[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one spi_ctrl engine between NUM_REQ command requesters.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_cmd_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CMD_WIDTH      = SPI_CMD_WIDTH,
  parameter int DATA_WIDTH     = SPI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]  i_req_cmd,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_err,
  output logic                          o_busy,
  output logic                          o_spi_en,
  output logic                          o_spi_ready,
  output logic [CMD_WIDTH-1:0]          o_spi_cmd,
  input  logic                          i_spi_sink_vld,
  input  logic [DATA_WIDTH-1:0]         i_spi_read_data
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int RW_BIT = CMD_WIDTH - 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("spi_cmd_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("spi_cmd_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e             r_state;
  logic [IDX_W-1:0]       r_last_grant;
  logic [IDX_W-1:0]       r_gnt_idx;
  logic [NUM_REQ-1:0]     r_gnt_oh;
  logic [NUM_REQ-1:0]     r_req_ready;
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_data;
  logic                   r_busy;
  logic                   r_spi_en;
  logic                   r_spi_ready;
  logic [CMD_WIDTH-1:0]   r_spi_cmd;

  logic [NUM_REQ-1:0]     w_grant;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_any;
  logic [CMD_WIDTH-1:0]   w_sel_cmd;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic             r_rsp_err;

  assign w_tmo_nxt = r_tmo_cnt + 1'b1;
  assign o_rsp_err = r_rsp_err;
`else
  assign o_rsp_err = 1'b0;
`endif

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req_valid  (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_idx        (w_idx),
    .o_any        (w_any)
  );

  always_comb begin
    w_sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel_cmd = i_req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
    end
  end

  // Output registers are loaded on the transition into the state they belong to,
  // so each pulse lines up with exactly one cycle of ISSUE or RESP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_gnt_idx    <= '0;
      r_gnt_oh     <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_busy       <= 1'b0;
      r_spi_en     <= 1'b0;
      r_spi_ready  <= 1'b0;
      r_spi_cmd    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      r_spi_en    <= 1'b1;
      r_req_ready <= '0;
      r_spi_ready <= 1'b0;
      r_rsp_valid <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_state     <= StIssue;
            r_busy      <= 1'b1;
            r_gnt_idx   <= w_idx;
            r_gnt_oh    <= w_grant;
            r_req_ready <= w_grant;
            r_spi_ready <= 1'b1;
            r_spi_cmd   <= w_sel_cmd;
          end
        end
        StIssue: begin
          r_last_grant <= r_gnt_idx;
          r_state      <= StWait;
`ifdef SPI_ARB_TIMEOUT_EN
          r_tmo_cnt    <= '0;
`endif
        end
        StWait: begin
          if (i_spi_sink_vld) begin
            r_rsp_data  <= r_spi_cmd[RW_BIT] ? '0 : i_spi_read_data;
            r_rsp_valid <= r_gnt_oh;
            r_state     <= StResp;
`ifdef SPI_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (w_tmo_nxt == TMO_LAST) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= r_gnt_oh;
            r_state     <= StResp;
          end else begin
            r_tmo_cnt   <= w_tmo_nxt;
`endif
          end
        end
        StResp: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = r_busy;
  assign o_spi_en    = r_spi_en;
  assign o_spi_ready = r_spi_ready;
  assign o_spi_cmd   = r_spi_cmd;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Scoreboard bench for spi_cmd_arbiter with a simple spi_ctrl engine model.
// The timeout scenario runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_cmd_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 24;
  localparam int DW   = 8;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO  = 16;
`else
  localparam int TMO  = 1024;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*CW-1:0] req_cmd = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              spi_en;
  logic              spi_ready;
  logic [CW-1:0]     spi_cmd;
  logic              sink_vld = 1'b0;
  logic [DW-1:0]     read_data = '0;

  spi_cmd_arbiter #(
    .NUM_REQ        (NREQ),
    .CMD_WIDTH      (CW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .i_req_cmd       (req_cmd),
    .o_req_ready     (req_ready),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_data      (rsp_data),
    .o_rsp_err       (rsp_err),
    .o_busy          (busy),
    .o_spi_en        (spi_en),
    .o_spi_ready     (spi_ready),
    .o_spi_cmd       (spi_cmd),
    .i_spi_sink_vld  (sink_vld),
    .i_spi_read_data (read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [CW-1:0] cmd;
  } gnt_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    bit            err;
    int            at_cyc;  // -1: expect one cycle after the engine's sink_vld
  } rsp_t;

  gnt_t          gnt_q[$];
  rsp_t          rsp_q[$];
  logic [DW-1:0] eng_data_q[$];
  gnt_t          mg;
  rsp_t          mr;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rsp = 0;
  int sink_cyc = -10;
  int last_rsp_cyc = -10;
  int eng_delay = 4;
  int eng_cnt = 0;
  bit eng_mute = 1'b0;
  bit stray_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: answers each spi_ready after eng_delay cycles unless muted.
  always @(negedge clk) begin
    sink_vld = 1'b0;
    if (stray_req) begin
      sink_vld  = 1'b1;
      read_data = 8'hEE;
      stray_req = 1'b0;
    end else if (eng_cnt != 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        sink_vld  = 1'b1;
        read_data = (eng_data_q.size() != 0) ? eng_data_q.pop_front() : 8'hFF;
        sink_cyc  = cyc;
      end
    end else if (spi_ready && !eng_mute) begin
      eng_cnt = eng_delay;
    end
  end

  // Monitor: pops expected grants and responses whenever the DUT presents them.
  always @(negedge clk) begin
    if (spi_ready) chk("ready_gap_after_rsp", 64'(cyc - last_rsp_cyc >= 2), 64'd1);
    if (req_ready != '0) begin
      if (gnt_q.size() == 0) begin
        chk("unexpected_grant", 64'(req_ready), 64'd0);
      end else begin
        mg = gnt_q.pop_front();
        chk("grant_onehot", 64'(req_ready), 64'd1 << mg.idx);
        chk("grant_spi_ready", 64'(spi_ready), 64'd1);
        chk("grant_spi_cmd", 64'(spi_cmd), 64'(mg.cmd));
      end
    end
    if (rsp_valid != '0) begin
      n_rsp++;
      last_rsp_cyc = cyc;
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        mr = rsp_q.pop_front();
        chk("rsp_onehot", 64'(rsp_valid), 64'd1 << mr.idx);
        chk("rsp_data", 64'(rsp_data), 64'(mr.data));
        chk("rsp_err", 64'(rsp_err), 64'(mr.err));
        chk("rsp_latency", 64'(cyc), 64'((mr.at_cyc >= 0) ? mr.at_cyc : sink_cyc + 1));
      end
    end
  end

  task automatic set_cmd(input int idx, input logic [CW-1:0] cmd);
    req_cmd[idx*CW +: CW] = cmd;
  endtask

  task automatic wait_ready(input int idx, input bit chk_lat, output int at);
    int n = 0;
    at = -1;
    @(negedge clk);
    if (chk_lat) chk("ready_latency", 64'(req_ready[idx]), 64'd1);
    while (!req_ready[idx] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[idx]) begin
      at = cyc;
      req_valid[idx] = 1'b0;
    end else begin
      chk("ready_wait_expired", 64'd0, 64'd1);
    end
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (n_rsp < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", 64'(n_rsp >= target), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic single(input int idx, input logic [CW-1:0] cmd, input logic [DW-1:0] eng_rd,
                        input logic [DW-1:0] exp_rd);
    int at;
    int base;
    base = n_rsp;
    set_cmd(idx, cmd);
    gnt_q.push_back('{idx, cmd});
    eng_data_q.push_back(eng_rd);
    rsp_q.push_back('{idx, exp_rd, 1'b0, -1});
    req_valid[idx] = 1'b1;
    wait_ready(idx, 1'b1, at);
    wait_rsp(base + 1);
  endtask

  initial begin
    int at;
    int base;
    logic [CW-1:0] c;

    // Reset values, then spi_en rises on the first clock after release.
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_err, busy, spi_en,
                              spi_ready, spi_cmd}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("spi_en_after_release", 64'(spi_en), 64'd1);
    chk("idle_not_busy", 64'(busy), 64'd0);

    // Stray sink_vld in IDLE must be ignored.
    base = n_rsp;
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_idle_busy", 64'(busy), 64'd0);
    chk("stray_idle_no_rsp", 64'(n_rsp), 64'(base));

    // Round-robin with all requesters held valid: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NREQ; i++) set_cmd(i, 24'h001000 + 24'(i));
    for (int k = 0; k < 8; k++) begin
      c = 24'h001000 + 24'(k % NREQ);
      gnt_q.push_back('{k % NREQ, c});
      eng_data_q.push_back(8'h10 + 8'(k));
      rsp_q.push_back('{k % NREQ, 8'h10 + 8'(k), 1'b0, -1});
    end
    base = n_rsp;
    req_valid = '1;
    begin
      int n = 0;
      while (n_rsp < base + 8 && n < 600) begin
        @(negedge clk);
        n++;
      end
    end
    req_valid = '0;
    chk("rr_all_served", 64'(n_rsp - base), 64'd8);
    repeat (3) @(negedge clk);

    // Single read and single write.
    single(2, 24'h012300, 8'hA5, 8'hA5);
    single(0, 24'h8055AA, 8'h3C, 8'h00);

    // Reset while waiting on the engine; pending 1 and 3 are served 1 first.
    eng_mute = 1'b1;
    set_cmd(0, 24'h000777);
    gnt_q.push_back('{0, 24'h000777});
    req_valid[0] = 1'b1;
    wait_ready(0, 1'b1, at);
    set_cmd(1, 24'h000111);
    set_cmd(3, 24'h000333);
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    repeat (3) @(negedge clk);
    chk("wait_busy", 64'(busy), 64'd1);
    base = n_rsp;
    rst = 1'b1;
    #1;
    chk("reset_mid_wait_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_err, busy, spi_en,
                                       spi_ready, spi_cmd}), 64'd0);
    repeat (2) @(negedge clk);
    chk("reset_mid_wait_no_rsp", 64'(n_rsp), 64'(base));
    eng_mute = 1'b0;
    gnt_q.push_back('{1, 24'h000111});
    gnt_q.push_back('{3, 24'h000333});
    eng_data_q.push_back(8'h5A);
    eng_data_q.push_back(8'h6B);
    rsp_q.push_back('{1, 8'h5A, 1'b0, -1});
    rsp_q.push_back('{3, 8'h6B, 1'b0, -1});
    rst = 1'b0;
    wait_ready(1, 1'b1, at);
    chk("spi_en_after_mid_reset", 64'(spi_en), 64'd1);
    wait_ready(3, 1'b0, at);
    wait_rsp(base + 2);

`ifdef SPI_ARB_TIMEOUT_EN
    // No sink_vld: error response 16 cycles after ISSUE; later stray is ignored.
    eng_mute = 1'b1;
    base = n_rsp;
    set_cmd(2, 24'h000222);
    gnt_q.push_back('{2, 24'h000222});
    req_valid[2] = 1'b1;
    wait_ready(2, 1'b1, at);
    rsp_q.push_back('{2, 8'h00, 1'b1, at + TMO});
    wait_rsp(base + 1);
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("late_sink_no_rsp", 64'(n_rsp), 64'(base + 1));
    eng_mute = 1'b0;
`endif

    repeat (4) @(negedge clk);
    chk("grant_queue_drained", 64'(gnt_q.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_cmd_arbiter.md
# spi_cmd_arbiter

Shares one `spi_ctrl` SPI engine between `NUM_REQ` command requesters. Round-robin arbitration picks one pending 24-bit command and issues it to the engine with a one-cycle `ready` pulse. It waits for the engine's `sink_vld`, then returns the read byte, or zero for writes, to the granted requester. It sits between the register-access clients and `spi_ctrl`, and is the only block that drives the engine's `en`, `ready` and `cmd_data` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CMD_WIDTH`, 24: command width; bit `CMD_WIDTH-1` is the R/W flag (1 = write, 0 = read).
- `DATA_WIDTH`, 8: read data width.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in WAIT; used only with `SPI_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester command pending.
- `req_cmd`  in  `NUM_REQ*CMD_WIDTH`  packed commands; requester i uses `[i*CMD_WIDTH +: CMD_WIDTH]`.
- `req_ready`  out  `NUM_REQ`  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  `NUM_REQ`  one-hot, one-cycle response pulse.
- `rsp_data`  out  `DATA_WIDTH`  response data, valid with `rsp_valid`.
- `rsp_err`  out  1  timeout flag, valid with `rsp_valid`.
- `busy`  out  1  high whenever state is not IDLE.
- `spi_en`  out  1  to engine `en`.
- `spi_ready`  out  1  to engine `ready`.
- `spi_cmd`  out  `CMD_WIDTH`  to engine `cmd_data`.
- `spi_sink_vld`  in  1  from engine `sink_vld`.
- `spi_read_data`  in  `DATA_WIDTH`  from engine `read_data`.

## Operation
- All outputs are registered. Reset values:
  - `req_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `busy`, `spi_ready`, `spi_cmd` are 0.
  - `spi_en` is 0; it goes to 1 on the first clock after reset release and stays 1.
- The state machine has four states:
  - **IDLE**: if any `req_valid` is set, grant the first set bit searching upward, with wrap, from `last_grant+1`. Latch that requester's command and index, then go to ISSUE.
  - **ISSUE**: for exactly one cycle, `req_ready[g]=1`, `spi_ready=1` and `spi_cmd` = the latched command. `last_grant` is set to g. Go to WAIT.
  - **WAIT**: on `spi_sink_vld`, capture `spi_read_data` if the latched R/W bit is 0, otherwise capture 0. Go to RESP.
  - **RESP**: for one cycle, `rsp_valid[g]=1` with the captured `rsp_data`. Go to IDLE.
- `last_grant` resets to `NUM_REQ-1`, so requester 0 wins the first arbitration.
- `spi_cmd` holds its last value outside ISSUE.
- `spi_sink_vld` is ignored outside WAIT.
- Requester rules:
  - Hold `req_valid` and `req_cmd` stable until `req_ready`.
  - Dropping `req_valid` before the grant is legal; that request is simply not served.
  - A requester may re-assert `req_valid` in the cycle after its `req_ready`.
- Simultaneous events:
  - Requests arriving during a transaction wait in IDLE arbitration.
  - A requester whose `req_valid` rises in the same cycle as IDLE evaluation is eligible in that cycle.
- Reset mid-transaction returns to IDLE with all outputs at reset values. No response is generated. `spi_ctrl` shares `rst`.

## Timing
- `req_valid` high in IDLE at cycle N gives `req_ready` and `spi_ready` at N+1.
- `spi_sink_vld` at cycle M gives `rsp_valid` at M+1.
- The earliest next `spi_ready` is M+3, which guarantees the engine is back in its idle state.
- Arbitration overhead is 3 cycles per transaction plus the engine's SPI time.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.

## Configuration
- Macro: `SPI_ARB_TIMEOUT_EN`.
- **With the macro defined:**
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES-1` without `spi_sink_vld`, go to RESP with `rsp_err=1` and `rsp_data=0`.
  - A late `sink_vld` after timeout is ignored.
  - The counter width is `$clog2(TIMEOUT_CYCLES)`.
- **Without the macro:** WAIT has no limit, `rsp_err` is tied to 0, and no counter logic exists.

## Structure
- Package `spi_pkg` holds:
  - the state enum typedef (IDLE, ISSUE, WAIT, RESP);
  - `SPI_CMD_RW_BIT = 23`;
  - default width constants shared with `spi_ctrl` clients.
- Sub-module `spi_rr_pick` is a combinational round-robin picker: inputs are `req_valid` and `last_grant`; outputs are a one-hot grant and an index. The FSM, latches and counter remain in `spi_cmd_arbiter`.

## Test plan
- **Single read:** req 2 sends cmd 0x012300 → `req_ready[2]` and `spi_ready` one cycle later. Model drives `sink_vld` with read_data 0xA5 → `rsp_valid[2]`, `rsp_data=0xA5`, `rsp_err=0`.
- **Single write:** req 0 sends cmd 0x8055AA; model returns read_data 0x3C → `rsp_data=0x00`, `rsp_valid[0]` one cycle after `sink_vld`.
- **Round-robin:** all 4 requesters held valid for 8 transactions → grant order 0,1,2,3,0,1,2,3; no `spi_ready` within 2 cycles after any `rsp_valid`.
- **Reset mid-WAIT:** assert `rst` while in WAIT → all outputs 0 immediately; no `rsp_valid`. After release, a pending req 1 is granted before req 3.
- **Timeout (macro on, TIMEOUT_CYCLES=16):** no `sink_vld` → `rsp_valid` with `rsp_err=1` and `rsp_data=0` exactly 16 cycles after ISSUE. A later stray `sink_vld` produces no response.
- **Stray sink_vld:** `spi_sink_vld` pulsed in IDLE → no `rsp_valid`, state unchanged.
